// File: rtl/rt_rgu_sched_if.sv
// Bundle between the raster scheduler and its environment: frame configuration,
// the RGU start/valid handshake, credit return and frame status.
interface rt_rgu_sched_if #(
   parameter int DIM_W = 16
) ();
   logic [DIM_W-1:0] cfg_width;
   logic [DIM_W-1:0] cfg_height;
   logic             frame_start;
   logic             abort;
   logic             credit_return;
   logic             rgu_valid;
   logic             rgu_start;
   logic [31:0]      rgu_x;
   logic [31:0]      rgu_y;
   logic             busy;
   logic             frame_done;
   logic             frame_aborted;
   logic             err;

   modport master (
      output cfg_width, cfg_height, frame_start, abort, credit_return, rgu_valid,
      input  rgu_start, rgu_x, rgu_y, busy, frame_done, frame_aborted, err
   );

   modport slave (
      input  cfg_width, cfg_height, frame_start, abort, credit_return, rgu_valid,
      output rgu_start, rgu_x, rgu_y, busy, frame_done, frame_aborted, err
   );
endinterface

// File: rtl/rt_rgu_sched.sv
// Raster-scan scheduler for the ray generation unit: one credit-throttled start
// per pixel, in-flight tracking, and frame completion once the pipeline drains.
module rt_rgu_sched #(
   parameter int FRAC_BITS = 16,
   parameter int CREDITS   = 8,
   parameter int DIM_W     = 16
) (
   input  logic           clk,
   input  logic           resetn,
   rt_rgu_sched_if.slave  bus
);
   localparam int CNT_W = $clog2(CREDITS + 1);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

   logic [1:0]       state_q, state_d;
   logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
   logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
   logic [CNT_W-1:0] credits_q, credits_d, outst_q, outst_d;
   logic             start_q, start_d, done_q, done_d;
   logic             aborted_q, aborted_d, err_q, err_d;
   logic [31:0]      x_q, x_d, y_q, y_d;
   logic             issue_s, cred_err_s, valid_err_s;

   function automatic logic [31:0] to_coord(input logic [DIM_W-1:0] idx);
      logic [31:0] ext;
      ext = 32'(idx);
      return ext << FRAC_BITS;
   endfunction

   // Issue uses the registered credit count only, so a same-cycle return cannot enable it.
   assign issue_s = (state_q == ST_RUN) && !bus.abort && (credits_q != CNT_W'(0));

   // Credit pool: spend on issue, refill on return; a return into a full pool is an error.
   always_comb begin
      credits_d  = credits_q;
      cred_err_s = 1'b0;
      case ({issue_s, bus.credit_return})
         2'b10: credits_d = credits_q - CNT_W'(1);
         2'b01: begin
            if (credits_q == CRED_MAX) begin
               cred_err_s = 1'b1;
            end else begin
               credits_d = credits_q + CNT_W'(1);
            end
         end
         default: credits_d = credits_q;
      endcase
   end

   // In-flight rays: +1 per issue, -1 per retired ray; a retire with nothing in flight is an error.
   always_comb begin
      outst_d     = outst_q;
      valid_err_s = 1'b0;
      case ({issue_s, bus.rgu_valid})
         2'b10: outst_d = outst_q + CNT_W'(1);
         2'b01: begin
            if (outst_q == CNT_W'(0)) begin
               valid_err_s = 1'b1;
            end else begin
               outst_d = outst_q - CNT_W'(1);
            end
         end
         default: outst_d = outst_q;
      endcase
   end

   // Frame sequencing, raster walk and registered RGU start/coordinates.
   always_comb begin
      state_d   = state_q;
      width_d   = width_q;
      height_d  = height_q;
      col_d     = col_q;
      row_d     = row_q;
      start_d   = 1'b0;
      done_d    = 1'b0;
      x_d       = x_q;
      y_d       = y_q;
      aborted_d = aborted_q;
      err_d     = err_q | cred_err_s | valid_err_s;
      case (state_q)
         ST_IDLE: begin
            if (bus.frame_start) begin
               width_d   = bus.cfg_width;
               height_d  = bus.cfg_height;
               col_d     = DIM_W'(0);
               row_d     = DIM_W'(0);
               aborted_d = 1'b0;
               if ((bus.cfg_width == DIM_W'(0)) || (bus.cfg_height == DIM_W'(0))) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               state_d   = ST_DRAIN;
               aborted_d = 1'b1;
            end else if (issue_s) begin
               start_d = 1'b1;
               x_d     = to_coord(col_q);
               y_d     = to_coord(row_q);
               if (col_q == width_q - DIM_W'(1)) begin
                  col_d = DIM_W'(0);
                  if (row_q == height_q - DIM_W'(1)) begin
                     state_d = ST_DRAIN;
                  end else begin
                     row_d = row_q + DIM_W'(1);
                  end
               end else begin
                  col_d = col_q + DIM_W'(1);
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // Looking at the post-update count lets done follow the last retire by one cycle.
            if (outst_d == CNT_W'(0)) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         width_q   <= DIM_W'(0);
         height_q  <= DIM_W'(0);
         col_q     <= DIM_W'(0);
         row_q     <= DIM_W'(0);
         credits_q <= CRED_MAX;
         outst_q   <= CNT_W'(0);
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         x_q       <= 32'd0;
         y_q       <= 32'd0;
         aborted_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         width_q   <= width_d;
         height_q  <= height_d;
         col_q     <= col_d;
         row_q     <= row_d;
         credits_q <= credits_d;
         outst_q   <= outst_d;
         start_q   <= start_d;
         done_q    <= done_d;
         x_q       <= x_d;
         y_q       <= y_d;
         aborted_q <= aborted_d;
         err_q     <= err_d;
      end
   end

   assign bus.rgu_start     = start_q;
   assign bus.rgu_x         = x_q;
   assign bus.rgu_y         = y_q;
   assign bus.busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign bus.frame_done    = done_q;
   assign bus.frame_aborted = aborted_q;
   assign bus.err           = err_q;
endmodule
